// File: rtl/npu_bus_master_pkg.sv
// Shared types for the NPU bus initiator: bus response/transfer encodings and FSM states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package npu_bus_master_pkg;

    typedef enum logic {
        RespOkay  = 1'b0,
        RespError = 1'b1
    } resp_e;

    typedef enum logic [1:0] {
        TransIdle   = 2'b00,
        TransNonseq = 2'b10
    } trans_e;

    typedef enum logic [1:0] {
        StIdle  = 2'b00,
        StBurst = 2'b01,
        StDrain = 2'b10
    } state_e;

    // Every beat is one word; consecutive beats advance by this many bytes.
    localparam int unsigned BeatStride = 4;

endpackage

// File: rtl/npu_bus_master_dff.sv
// Generic register with enable and asynchronous active-low reset to a parameter value.
// Latency: 1 cycle from d_i to q_o when en_i is high.
// Backpressure: none; en_i low holds the stored value.
module npu_bus_master_dff #(
    parameter int               Width  = 1,
    parameter logic [Width-1:0] RstVal = '0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             en_i,
    input  logic [Width-1:0] d_i,
    output logic [Width-1:0] q_o
);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            q_o <= RstVal;
        end else if (en_i) begin
            q_o <= d_i;
        end
    end

endmodule

// File: rtl/npu_bus_master.sv
// Bus initiator: turns burst commands into single-beat NONSEQ transfers, read data as a strobe stream.
// Latency: first address phase 1 cycle after command handshake; read strobe 2 cycles after address accept.
// Backpressure: ready_i low freezes address and data phases; write beats wait on wvalid_i.
module npu_bus_master
    import npu_bus_master_pkg::*;
#(
    parameter int DWidth   = 32,
    parameter int LenWidth = 4
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                cmd_valid_i,
    output logic                cmd_ready_o,
    input  logic                cmd_write_i,
    input  logic [DWidth-1:0]   cmd_addr_i,
    input  logic [LenWidth-1:0] cmd_len_i,
    input  logic                wvalid_i,
    input  logic [DWidth-1:0]   wdata_i,
    output logic                wready_o,
    output logic                rvalid_o,
    output logic [DWidth-1:0]   rdata_o,
    output logic                done_o,
    output logic                err_o,
    output logic                sel_o,
    output logic [1:0]          trans_o,
    output logic                write_o,
    output logic [DWidth-1:0]   addr_o,
    output logic [DWidth-1:0]   wdata_o,
    input  logic [DWidth-1:0]   rdata_i,
    input  logic                resp_i,
    input  logic                ready_i
);

    localparam int CntWidth = LenWidth + 1;

    state_e              state_q;
    state_e              state_d;
    logic [1:0]          state_raw;
    logic [CntWidth-1:0] beats_left_q;
    logic [CntWidth-1:0] beats_left_d;
    logic                write_q;
    logic [DWidth-1:0]   next_addr_q;
    logic [DWidth-1:0]   next_addr_d;
    logic [DWidth-1:0]   beat_addr;
    logic                err_flag_q;
    logic                err_flag_d;
    logic                dp_vld_q;
    logic                dp_write_q;
    logic                cmd_fire;
    logic                burst_write;
    logic                have_beat;
    logic                err_now;
    logic                load;
    logic                drain_exit;
    logic                rd_strobe;
    logic [1:0]          trans_d;

    assign state_q     = state_e'(state_raw);
    assign cmd_ready_o = (state_q == StIdle);
    assign cmd_fire    = cmd_ready_o & cmd_valid_i;
    assign err_now     = dp_vld_q & ready_i & (resp_e'(resp_i) == RespError);

    // The first beat loads in the handshake cycle itself, straight from the command inputs.
    assign burst_write = cmd_fire ? cmd_write_i : write_q;
    assign beat_addr   = cmd_fire ? cmd_addr_i : next_addr_q;
    assign have_beat   = cmd_fire
                       | ((state_q == StBurst) & (beats_left_q != '0) & !err_flag_q & !err_now);

    // ready_i high means the slot is free: either empty or its beat is accepted this cycle.
    assign load      = ready_i & have_beat & (!burst_write | wvalid_i);
    assign wready_o  = load & burst_write;
    assign rd_strobe = dp_vld_q & ready_i & !dp_write_q & !err_now & !err_flag_q;
    assign trans_d   = load ? TransNonseq : TransIdle;

    always_comb begin
        state_d    = state_q;
        drain_exit = 1'b0;
        case (state_q)
            StIdle: begin
                if (cmd_fire) begin
                    state_d = StBurst;
                end
            end
            StBurst: begin
                if (ready_i && !load && (beats_left_q == '0 || err_flag_q || err_now)) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                if (!dp_vld_q || ready_i) begin
                    drain_exit = 1'b1;
                    state_d    = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        beats_left_d = cmd_fire ? ({1'b0, cmd_len_i} + CntWidth'(1)) : beats_left_q;
        beats_left_d = beats_left_d - CntWidth'(load);
        next_addr_d  = load ? (beat_addr + DWidth'(BeatStride)) : beat_addr;
        err_flag_d   = !cmd_fire & (err_flag_q | err_now);
    end

    npu_bus_master_dff #(.Width(2)) u_state (
        .clk_i(clk_i), .rst_ni(rst_ni), .en_i(1'b1), .d_i(state_d), .q_o(state_raw)
    );
    npu_bus_master_dff #(.Width(CntWidth)) u_beats_left (
        .clk_i(clk_i), .rst_ni(rst_ni), .en_i(cmd_fire | load), .d_i(beats_left_d), .q_o(beats_left_q)
    );
    npu_bus_master_dff #(.Width(1)) u_write (
        .clk_i(clk_i), .rst_ni(rst_ni), .en_i(cmd_fire), .d_i(cmd_write_i), .q_o(write_q)
    );
    npu_bus_master_dff #(.Width(DWidth)) u_next_addr (
        .clk_i(clk_i), .rst_ni(rst_ni), .en_i(cmd_fire | load), .d_i(next_addr_d), .q_o(next_addr_q)
    );
    npu_bus_master_dff #(.Width(1)) u_err_flag (
        .clk_i(clk_i), .rst_ni(rst_ni), .en_i(1'b1), .d_i(err_flag_d), .q_o(err_flag_q)
    );

    // Address-phase slot.
    npu_bus_master_dff #(.Width(1)) u_sel (
        .clk_i(clk_i), .rst_ni(rst_ni), .en_i(ready_i), .d_i(load), .q_o(sel_o)
    );
    npu_bus_master_dff #(.Width(2)) u_trans (
        .clk_i(clk_i), .rst_ni(rst_ni), .en_i(ready_i), .d_i(trans_d), .q_o(trans_o)
    );
    npu_bus_master_dff #(.Width(1)) u_write_o (
        .clk_i(clk_i), .rst_ni(rst_ni), .en_i(ready_i), .d_i(load & burst_write), .q_o(write_o)
    );
    npu_bus_master_dff #(.Width(DWidth)) u_addr (
        .clk_i(clk_i), .rst_ni(rst_ni), .en_i(load), .d_i(beat_addr), .q_o(addr_o)
    );
    npu_bus_master_dff #(.Width(DWidth)) u_wdata (
        .clk_i(clk_i), .rst_ni(rst_ni), .en_i(load), .d_i(burst_write ? wdata_i : '0), .q_o(wdata_o)
    );

    // Data-phase tracking: the beat accepted last cycle is now in its data phase.
    npu_bus_master_dff #(.Width(1)) u_dp_vld (
        .clk_i(clk_i), .rst_ni(rst_ni), .en_i(ready_i), .d_i(sel_o), .q_o(dp_vld_q)
    );
    npu_bus_master_dff #(.Width(1)) u_dp_write (
        .clk_i(clk_i), .rst_ni(rst_ni), .en_i(ready_i), .d_i(write_o), .q_o(dp_write_q)
    );

    npu_bus_master_dff #(.Width(1)) u_rvalid (
        .clk_i(clk_i), .rst_ni(rst_ni), .en_i(1'b1), .d_i(rd_strobe), .q_o(rvalid_o)
    );
    npu_bus_master_dff #(.Width(DWidth)) u_rdata (
        .clk_i(clk_i), .rst_ni(rst_ni), .en_i(rd_strobe), .d_i(rdata_i), .q_o(rdata_o)
    );
    npu_bus_master_dff #(.Width(1)) u_done (
        .clk_i(clk_i), .rst_ni(rst_ni), .en_i(1'b1), .d_i(drain_exit), .q_o(done_o)
    );
    npu_bus_master_dff #(.Width(1)) u_err (
        .clk_i(clk_i), .rst_ni(rst_ni), .en_i(1'b1), .d_i(drain_exit & (err_flag_q | err_now)), .q_o(err_o)
    );

endmodule
